// File: rtl/datapath_pkg.sv
// datapath_pkg: ALU opcodes, mul/div FSM states and default widths shared by param_datapath.
package datapath_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SHR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_NEG = 4'd6,
        ALU_NOT = 4'd7,
        ALU_MUL = 4'd8,
        ALU_DIV = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } muldiv_state_t;
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative signed multiply (shift-add) and restoring divide on latched magnitudes.
// The divide datapath exists only when DATAPATH_DIV_EN is defined.
module seq_muldiv
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  load,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
);
    localparam int CW = $clog2(DATA_W);

    muldiv_state_t state, state_nx;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] acc, quo, mag_b, acc_nx, quo_nx;
    logic [DATA_W:0]   sum;
    logic              sign_q;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    assign busy = state == MUL || state == DIV;
    assign load = busy && cnt == CW'(DATA_W - 1);
    assign done = state == FIN;

    always_comb begin
        state_nx = busy ? (load ? FIN : state) : start ? (is_div ? DIV : MUL) : IDLE;
    end

    // acc is the product high half or the partial remainder; quo is the multiplier or quotient
    assign sum = {1'b0, acc} + {1'b0, mag_b & {DATA_W{quo[0]}}};

`ifdef DATAPATH_DIV_EN
    logic [DATA_W:0] shl;
    logic            ge, sign_r;

    assign shl    = {acc, quo[DATA_W-1]};
    assign ge     = shl >= {1'b0, mag_b};
    assign acc_nx = state == DIV ? (ge ? DATA_W'(shl - {1'b0, mag_b}) : shl[DATA_W-1:0]) : sum[DATA_W:1];
    assign quo_nx = state == DIV ? {quo[DATA_W-2:0], ge} : {sum[0], quo[DATA_W-1:1]};
    assign result = state == DIV ? {sign_r ? -acc_nx : acc_nx, sign_q ? -quo_nx : quo_nx}
                                 : (sign_q ? -{acc_nx, quo_nx} : {acc_nx, quo_nx});

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) sign_r <= 1'b0;
        else if (start) sign_r <= a[DATA_W-1];
    end
`else
    assign acc_nx = sum[DATA_W:1];
    assign quo_nx = {sum[0], quo[DATA_W-1:1]};
    assign result = sign_q ? -{acc_nx, quo_nx} : {acc_nx, quo_nx};
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            quo    <= '0;
            mag_b  <= '0;
            sign_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt    <= '0;
                acc    <= '0;
                quo    <= mag(a);
                mag_b  <= mag(b);
                sign_q <= a[DATA_W-1] ^ b[DATA_W-1];
            end else if (busy) begin
                cnt <= cnt + CW'(1);
                acc <= acc_nx;
                quo <= quo_nx;
            end
        end
    end
endmodule

// File: rtl/param_datapath.sv
// param_datapath: one-hot shared-bus register datapath with single-cycle ALU and sequential mul/div.
// Define DATAPATH_DIV_EN to build the signed divider; otherwise op 9 is treated as illegal.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] Rin,
    input  logic [NUM_REGS-1:0] Rout,
    input  logic                PCin,
    input  logic                PCout,
    input  logic                IncPC,
    input  logic                IRin,
    input  logic                Yin,
    input  logic                Yout,
    input  logic                MARin,
    input  logic                MDRin,
    input  logic                MDRout,
    input  logic                HIin,
    input  logic                HIout,
    input  logic                LOin,
    input  logic                LOout,
    input  logic                Zhighout,
    input  logic                Zlowout,
    input  logic                Read,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic [3:0]          alu_op,
    input  logic                alu_start,
    output logic [DATA_W-1:0]   BusMuxOut,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   ir_out,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                bus_conflict,
    output logic                illegal_op
);
    localparam int SW = $clog2(DATA_W);
`ifdef DATAPATH_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [DATA_W-1:0]   gpr [NUM_REGS];
    logic [DATA_W-1:0]   pc, ir, y, mar, mdr, hi, lo, z_hi, z_lo;
    logic [DATA_W-1:0]   bus_or, sc_lo;
    logic [SW-1:0]       shamt;
    logic [2*DATA_W-1:0] md_result;
    logic accept, is_div, div_zero, md_start, sc_go, bad_op, md_load, md_done, done_q, illegal_q;

    always_comb begin
        bus_or = (PCout ? pc : '0) | (Yout ? y : '0) | (MDRout ? mdr : '0) | (HIout ? hi : '0)
               | (LOout ? lo : '0) | (Zhighout ? z_hi : '0) | (Zlowout ? z_lo : '0);
        for (int i = 0; i < NUM_REGS; i++) bus_or = bus_or | (Rout[i] ? gpr[i] : '0);
    end

    assign bus_conflict = !$onehot0({Rout, PCout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout});
    assign BusMuxOut    = bus_conflict ? '0 : bus_or;
    assign mem_addr     = mar;
    assign ir_out       = ir;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mar <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) if (Rin[i]) gpr[i] <= BusMuxOut;
            if (IncPC) pc <= pc + DATA_W'(1);
            else if (PCin) pc <= BusMuxOut;
            if (IRin) ir <= BusMuxOut;
            if (Yin) y <= BusMuxOut;
            if (MARin) mar <= BusMuxOut;
            if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
            if (HIin) hi <= BusMuxOut;
            if (LOin) lo <= BusMuxOut;
        end
    end

    // starts arriving while the sequential unit is busy are dropped silently
    assign accept   = alu_start && !alu_busy;
    assign is_div   = DIV_EN && alu_op == ALU_DIV;
    assign div_zero = accept && is_div && BusMuxOut == '0;
    assign md_start = accept && (alu_op == ALU_MUL || (is_div && BusMuxOut != '0));
    assign sc_go    = accept && alu_op < 4'd8;
    assign bad_op   = accept && alu_op > 4'd8 && !is_div;
    assign shamt    = BusMuxOut[SW-1:0];

    // unary NEG/NOT act on the bus operand
    always_comb begin
        case (alu_op)
            ALU_ADD: sc_lo = y + BusMuxOut;
            ALU_SUB: sc_lo = y - BusMuxOut;
            ALU_AND: sc_lo = y & BusMuxOut;
            ALU_OR:  sc_lo = y | BusMuxOut;
            ALU_SHR: sc_lo = y >> shamt;
            ALU_SHL: sc_lo = y << shamt;
            ALU_NEG: sc_lo = -BusMuxOut;
            ALU_NOT: sc_lo = ~BusMuxOut;
            default: sc_lo = '0;
        endcase
    end

    seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clock  (clock),
        .clear  (clear),
        .start  (md_start),
        .is_div (is_div),
        .a      (y),
        .b      (BusMuxOut),
        .busy   (alu_busy),
        .load   (md_load),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_hi      <= '0;
            z_lo      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= sc_go || div_zero;
            illegal_q <= bad_op;
            if (md_load) {z_hi, z_lo} <= md_result;
            else if (sc_go) begin
                z_hi <= '0;
                z_lo <= sc_lo;
            end else if (div_zero) begin
                z_hi <= y;
                z_lo <= '1;
            end
        end
    end

    assign alu_done   = done_q || md_done;
    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: directed and random checks of param_datapath against an arithmetic reference model.
module tb_param_datapath;
    localparam int W = 32;
    localparam int N = 16;

    logic clock = 1'b0, clear = 1'b0;
    logic [N-1:0] Rin = '0, Rout = '0;
    logic PCin = 0, PCout = 0, IncPC = 0, IRin = 0, Yin = 0, Yout = 0, MARin = 0, MDRin = 0, MDRout = 0;
    logic HIin = 0, HIout = 0, LOin = 0, LOout = 0, Zhighout = 0, Zlowout = 0, Read = 0, alu_start = 0;
    logic [W-1:0] Mdatain = '0;
    logic [3:0] alu_op = '0;
    logic [W-1:0] BusMuxOut, mem_addr, ir_out;
    logic alu_busy, alu_done, bus_conflict, illegal_op;

    int errors = 0, checks = 0;
    logic [W-1:0] zh_m = '0, zl_m = '0;

    param_datapath #(.DATA_W(W), .NUM_REGS(N)) dut (
        .clock(clock), .clear(clear), .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
        .IRin(IRin), .Yin(Yin), .Yout(Yout), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin),
        .HIout(HIout), .LOin(LOin), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .Read(Read),
        .Mdatain(Mdatain), .alu_op(alu_op), .alu_start(alu_start), .BusMuxOut(BusMuxOut),
        .mem_addr(mem_addr), .ir_out(ir_out), .alu_busy(alu_busy), .alu_done(alu_done),
        .bus_conflict(bus_conflict), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick;
        Read = 0; MDRin = 0;
    endtask

    task automatic read_z(input string tag);
        Zlowout = 1; #1;
        check({tag, " zlo"}, BusMuxOut, zl_m);
        Zlowout = 0; Zhighout = 1; #1;
        check({tag, " zhi"}, BusMuxOut, zh_m);
        Zhighout = 0; #1;
    endtask

    // Reference: signed results from plain 64-bit arithmetic
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output bit multi, output bit done, output bit ill);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p;
        multi = 0; done = 1; ill = 0;
        case (op)
            4'd0: begin zh_m = '0; zl_m = a + b; end
            4'd1: begin zh_m = '0; zl_m = a - b; end
            4'd2: begin zh_m = '0; zl_m = a & b; end
            4'd3: begin zh_m = '0; zl_m = a | b; end
            4'd4: begin zh_m = '0; zl_m = a >> (b % W); end
            4'd5: begin zh_m = '0; zl_m = a << (b % W); end
            4'd6: begin zh_m = '0; zl_m = -b; end
            4'd7: begin zh_m = '0; zl_m = ~b; end
            4'd8: begin p = sa * sb; {zh_m, zl_m} = p; multi = 1; end
`ifdef DATAPATH_DIV_EN
            4'd9: if (b == '0) begin zl_m = '1; zh_m = a; end
                  else begin zl_m = W'(sa / sb); zh_m = W'(sa % sb); multi = 1; end
`endif
            default: begin done = 0; ill = 1; end
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input bit poke);
        bit multi, done_m, ill_m;
        int n;
        load_mdr(a);
        MDRout = 1; Yin = 1;
        tick;
        Yin = 0; MDRout = 0;
        load_mdr(b);
        MDRout = 1; alu_op = op; alu_start = 1;
        tick;
        MDRout = 0; alu_start = 0;
        model(op, a, b, multi, done_m, ill_m);
        check({tag, " illegal"}, W'(illegal_op), W'(ill_m));
        check({tag, " busy"}, W'(alu_busy), W'(multi));
        if (multi) begin
            n = 0;
            while (alu_busy && n < 100) begin
                n++;
                if (poke && n == 3) begin alu_op = 4'd0; alu_start = 1; end
                tick;
                alu_start = 0;
            end
            check({tag, " busy cycles"}, W'(n), W'(W));
        end
        check({tag, " done"}, W'(alu_done), W'(done_m));
        tick;
        check({tag, " done pulse end"}, W'(alu_done), '0);
        read_z(tag);
    endtask

    initial begin
        bit saw_done;
        repeat (2) @(posedge clock);
        #1;
        check("rst mem_addr", mem_addr, '0);
        check("rst ir_out", ir_out, '0);
        check("rst busy", W'(alu_busy), '0);
        check("rst done", W'(alu_done), '0);
        check("rst illegal", W'(illegal_op), '0);
        check("rst conflict", W'(bus_conflict), '0);
        clear = 1;
        #1;
        read_z("rst");
        PCout = 1; #1;
        check("rst pc", BusMuxOut, '0);

        IncPC = 1;
        tick;
        check("pc inc old value same cycle", BusMuxOut, W'(1));
        PCin = 1;
        tick;
        PCin = 0; IncPC = 0;
        check("incpc priority", BusMuxOut, W'(2));
        MDRin = 1; Read = 0;
        tick;
        MDRin = 0; PCout = 0; MDRout = 1; #1;
        check("mdr from bus", BusMuxOut, W'(2));
        MDRout = 0;
        load_mdr('1);
        MDRout = 1; PCin = 1;
        tick;
        MDRout = 0; PCin = 0; IncPC = 1;
        tick;
        IncPC = 0; PCout = 1; #1;
        check("pc wrap", BusMuxOut, '0);
        PCout = 0;

        load_mdr(32'h0000_000A);
        MDRout = 1; Rin[1] = 1;
        tick;
        Rin = '0; MDRout = 0;
        load_mdr(32'h0000_000B);
        MDRout = 1; Rin[2] = 1; MARin = 1; IRin = 1;
        tick;
        Rin = '0; MDRout = 0; MARin = 0; IRin = 0;
        check("mem_addr", mem_addr, 32'h0000_000B);
        check("ir_out", ir_out, 32'h0000_000B);
        Rout = 16'h0006; #1;
        check("conflict bus", BusMuxOut, '0);
        check("conflict flag", W'(bus_conflict), W'(1));
        Rout = 16'h0002; #1;
        check("r1 bus", BusMuxOut, 32'h0000_000A);
        check("r1 flag", W'(bus_conflict), '0);
        Rout = 16'h0004; HIin = 1;
        tick;
        Rout = '0; HIin = 0; HIout = 1; #1;
        check("hi", BusMuxOut, 32'h0000_000B);
        LOout = 1; #1;
        check("hi lo conflict", W'(bus_conflict), W'(1));
        HIout = 0; LOout = 0; #1;
        check("idle bus", BusMuxOut, '0);

        do_op(4'd0, 32'd5, 32'd7, "add", 0);
        do_op(4'd8, 32'hFFFF_FFFD, 32'd7, "mul", 1);
        do_op(4'd9, 32'd17, 32'hFFFF_FFFB, "div", 0);
        do_op(4'd9, 32'd17, 32'd0, "div zero", 0);
        do_op(4'd12, 32'd1, 32'd2, "op12", 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 11));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) b = W'($urandom_range(0, 3));
            if (i % 7 == 0) a = 32'h8000_0000;
            do_op(op, a, b, "rnd", 0);
        end

        load_mdr(32'hFFFF_FFFD);
        MDRout = 1; Yin = 1;
        tick;
        Yin = 0; MDRout = 0;
        load_mdr(32'd7);
        MDRout = 1; alu_op = 4'd8; alu_start = 1;
        tick;
        MDRout = 0; alu_start = 0;
        repeat (9) tick;
        check("clr busy before", W'(alu_busy), W'(1));
        clear = 0; #1;
        check("clr busy drop", W'(alu_busy), '0);
        check("clr done", W'(alu_done), '0);
        tick;
        clear = 1;
        zh_m = '0; zl_m = '0;
        saw_done = 0;
        repeat (40) begin
            tick;
            if (alu_done) saw_done = 1;
        end
        check("clr no done", W'(saw_done), '0);
        read_z("clr");
        do_op(4'd0, 32'd5, 32'd7, "add after clr", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
